// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, 3-sample majority vote per bit, false-start rejection.
// Define UART_RX_BREAK_EN to add break detection (break_det port and S_BREAK_WAIT state).
//
// state        | meaning
// S_IDLE       | waiting for rx_s low while en_r is high; counters held at 0
// S_START      | start bit; a majority of 1 is a false start and returns to S_IDLE
// S_DATA       | shifting in DATA_BITS voted bits, LSB first
// S_PARITY     | voted parity bit compared with the parity of the shifted word
// S_STOP       | stop bit(s); the last vote publishes the word and flags
// S_BREAK_WAIT | after an all-zero frame, waits for one full bit time of idle line
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int BAUD_DIV   = 54
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_r,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 done,
    output logic                 error,
    output logic                 parity_err,
    output logic                 frame_err,
`ifdef UART_RX_BREAK_EN
    output logic                 break_det,
`endif
    output logic                 busy
);

    localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_DIV - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] MID_LO    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] MID_C     = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] MID_HI    = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_RX_BREAK_EN
        , S_BREAK_WAIT
`endif
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [TW-1:0]        tick_cnt;
    logic [SW-1:0]        samp_cnt;
    logic [SW-1:0]        samp_nxt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 v_lo;
    logic                 v_mid;
    logic                 par_pend;
    logic                 frm_pend;
`ifdef UART_RX_BREAK_EN
    logic                 all_zero;
`endif
    logic                 tick;
    logic                 bit_end;
    logic                 vote_pt;
    logic                 vote;
    logic                 par_exp;

    assign tick     = (tick_cnt == TICK_LAST);
    assign samp_nxt = (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + SW'(1);
    assign bit_end  = tick && (samp_cnt == SAMP_LAST);
    // Samples are taken on the tick that moves the counter onto MID-1, MID and MID+1.
    assign vote_pt  = tick && (samp_nxt == MID_HI);
    assign vote     = (v_lo & v_mid) | (v_lo & rx_s) | (v_mid & rx_s);
    assign par_exp  = (PARITY == 1) ? ~(^shreg) : ^shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            state      <= S_IDLE;
            tick_cnt   <= '0;
            samp_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            v_lo       <= 1'b0;
            v_mid      <= 1'b0;
            par_pend   <= 1'b0;
            frm_pend   <= 1'b0;
`ifdef UART_RX_BREAK_EN
            all_zero   <= 1'b0;
            break_det  <= 1'b0;
`endif
            data       <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_meta    <= Rx;
            rx_s       <= rx_meta;
            done       <= 1'b0;
            error      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_BREAK_EN
            break_det  <= 1'b0;
`endif
            if (state != S_IDLE) begin
                if (tick) begin
                    tick_cnt <= '0;
                    samp_cnt <= samp_nxt;
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                end
                if (tick && (samp_nxt == MID_LO)) v_lo  <= rx_s;
                if (tick && (samp_nxt == MID_C))  v_mid <= rx_s;
            end

            case (state)
                S_IDLE: begin
                    tick_cnt <= '0;
                    samp_cnt <= '0;
                    if (en_r && !rx_s) begin
                        state    <= S_START;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        par_pend <= 1'b0;
                        frm_pend <= 1'b0;
`ifdef UART_RX_BREAK_EN
                        all_zero <= 1'b1;
`endif
                    end
                end
                S_START: begin
                    if (vote_pt && vote) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        tick_cnt <= '0;
                        samp_cnt <= '0;
                    end else if (bit_end) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (vote_pt) begin
                        shreg <= {vote, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_EN
                        if (vote) all_zero <= 1'b0;
`endif
                    end
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (vote_pt) begin
                        if (vote != par_exp) par_pend <= 1'b1;
`ifdef UART_RX_BREAK_EN
                        if (vote) all_zero <= 1'b0;
`endif
                    end
                    if (bit_end) begin
                        state   <= S_STOP;
                        bit_cnt <= '0;
                    end
                end
                S_STOP: begin
                    if (bit_end) bit_cnt <= bit_cnt + 4'd1;
                    if (vote_pt) begin
                        if (!vote) frm_pend <= 1'b1;
`ifdef UART_RX_BREAK_EN
                        if (vote) all_zero <= 1'b0;
`endif
                        // Leave at mid-bit so a start edge right after the stop bit is not missed.
                        if (bit_cnt == STOP_LAST) begin
                            tick_cnt <= '0;
                            samp_cnt <= '0;
`ifdef UART_RX_BREAK_EN
                            if (all_zero && !vote) begin
                                break_det <= 1'b1;
                                state     <= S_BREAK_WAIT;
                            end else
`endif
                            begin
                                data       <= shreg;
                                done       <= 1'b1;
                                parity_err <= par_pend;
                                frame_err  <= frm_pend | !vote;
                                error      <= par_pend | frm_pend | !vote;
                                state      <= S_IDLE;
                                busy       <= 1'b0;
                            end
                        end
                    end
                end
`ifdef UART_RX_BREAK_EN
                S_BREAK_WAIT: begin
                    if (!rx_s) begin
                        tick_cnt <= '0;
                        samp_cnt <= '0;
                    end else if (bit_end) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        tick_cnt <= '0;
                        samp_cnt <= '0;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 receiver on rx_a and an 8E1 receiver on rx_b, 32 clk per bit.
module tb_uart_rx_param;

    localparam int BIT_CLK = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_r;
    logic       rx_a;
    logic       rx_b;
    logic [7:0] data_a, data_b;
    logic       done_a, error_a, parity_err_a, frame_err_a, busy_a;
    logic       done_b, error_b, parity_err_b, frame_err_b, busy_b;
`ifdef UART_RX_BREAK_EN
    logic       break_a, break_b;
`endif

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int done_cyc_a = 0;
    int n_done_a = 0;
    int n_done_b = 0;
    int n_break_a = 0;
    logic [7:0] cap_a, cap_b;
    logic       cap_err_a, cap_pe_a, cap_fe_a;
    logic       cap_err_b, cap_pe_b, cap_fe_b;

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(8), .BAUD_DIV(4)) u_8n1 (
        .clk(clk), .rst(rst), .en_r(en_r), .Rx(rx_a), .data(data_a), .done(done_a),
        .error(error_a), .parity_err(parity_err_a), .frame_err(frame_err_a),
`ifdef UART_RX_BREAK_EN
        .break_det(break_a),
`endif
        .busy(busy_a)
    );

    uart_rx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(8), .BAUD_DIV(4)) u_8e1 (
        .clk(clk), .rst(rst), .en_r(en_r), .Rx(rx_b), .data(data_b), .done(done_b),
        .error(error_b), .parity_err(parity_err_b), .frame_err(frame_err_b),
`ifdef UART_RX_BREAK_EN
        .break_det(break_b),
`endif
        .busy(busy_b)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done_a) begin
            n_done_a++;
            done_cyc_a = cyc;
            cap_a = data_a;
            cap_err_a = error_a;
            cap_pe_a = parity_err_a;
            cap_fe_a = frame_err_a;
        end
        if (done_b) begin
            n_done_b++;
            cap_b = data_b;
            cap_err_b = error_b;
            cap_pe_b = parity_err_b;
            cap_fe_b = frame_err_b;
        end
`ifdef UART_RX_BREAK_EN
        if (break_a) n_break_a++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input bit sel, input logic b);
        if (sel) rx_b = b;
        else rx_a = b;
    endtask

    task automatic send_bit(input bit sel, input logic b);
        drive(sel, b);
        repeat (BIT_CLK) @(negedge clk);
    endtask

    // Called on a negedge; leaves the line at the stop level so frames can run back to back.
    task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                              input logic pbit, input logic sbit);
        fall_cyc = cyc;
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
        if (has_par) send_bit(sel, pbit);
        send_bit(sel, sbit);
    endtask

    task automatic idle(input bit sel, input int nbits);
        drive(sel, 1'b1);
        repeat (nbits * BIT_CLK) @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        en_r = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_flags_a", {27'd0, done_a, error_a, parity_err_a, frame_err_a, busy_a}, 32'd0);
        check("reset_data_a", data_a, 32'h00);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 basic frame
        send_frame(1'b0, 8'h8A, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 1);
        check("t1_done_count", n_done_a, 1);
        check("t1_data", cap_a, 32'h8A);
        check("t1_flags", {cap_err_a, cap_pe_a, cap_fe_a}, 32'd0);
        check("t1_busy_low", busy_a, 1'b0);
        check("t1_latency_window", ((done_cyc_a - fall_cyc) >= 307) && ((done_cyc_a - fall_cyc) <= 315), 1'b1);

        // even parity: 0x8A has three ones, so the correct parity bit is 1
        send_frame(1'b1, 8'h8A, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 1);
        check("t2_done_count", n_done_b, 1);
        check("t2_data", cap_b, 32'h8A);
        check("t2_bad_parity_flags", {cap_err_b, cap_pe_b, cap_fe_b}, 32'b110);
        send_frame(1'b1, 8'h8A, 1'b1, 1'b1, 1'b1);
        idle(1'b1, 1);
        check("t2_done_count2", n_done_b, 2);
        check("t2_good_parity_flags", {cap_err_b, cap_pe_b, cap_fe_b}, 32'b000);

        // stop bit 0, then a back-to-back frame
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        check("t3_data_bad_stop", cap_a, 32'h55);
        check("t3_frame_flags", {cap_err_a, cap_pe_a, cap_fe_a}, 32'b101);
        send_frame(1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 1);
        check("t3_done_count", n_done_a, 3);
        check("t3_data_b2b", cap_a, 32'h0F);
        check("t3_error_b2b", cap_err_a, 1'b0);

        // 8-clk glitch is rejected as a false start
        rx_a = 1'b0;
        repeat (8) @(negedge clk);
        rx_a = 1'b1;
        repeat (BIT_CLK - 8) @(negedge clk);
        check("t4_glitch_busy", busy_a, 1'b0);
        check("t4_glitch_no_done", n_done_a, 3);
        idle(1'b0, 1);
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 1);
        check("t4_done_count", n_done_a, 4);
        check("t4_data", cap_a, 32'hA5);

        // reset after 4 data bits of 0xFF
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
        check("t5_busy_mid_frame", busy_a, 1'b1);
        rst = 1'b1;
        #1;
        check("t5_async_flags", {27'd0, done_a, error_a, parity_err_a, frame_err_a, busy_a}, 32'd0);
        check("t5_async_data", data_a, 32'h00);
        rx_a = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(1'b0, 2);
        check("t5_partial_discarded", n_done_a, 4);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 1);
        check("t5_data_after_reset", cap_a, 32'h3C);

        en_r = 1'b0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 1);
        check("t5_disabled_no_done", n_done_a, 5);
        check("t5_disabled_busy", busy_a, 1'b0);
        en_r = 1'b1;
        fork
            send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
            begin
                repeat (100) @(negedge clk);
                en_r = 1'b0;
            end
        join
        idle(1'b0, 1);
        check("t5_en_drop_done", n_done_a, 6);
        check("t5_en_drop_data", cap_a, 32'h22);
        en_r = 1'b1;

`ifdef UART_RX_BREAK_EN
        // 12 bit times low is a break
        rx_a = 1'b0;
        repeat (12 * BIT_CLK) @(negedge clk);
        idle(1'b0, 2);
        check("t6_break_count", n_break_a, 1);
        check("t6_break_no_done", n_done_a, 6);
        check("t6_break_data_held", data_a, 32'h22);
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 1);
        check("t6_data_after_break", cap_a, 32'h81);
`else
        // all-zero frame without break support is a framing error carrying data 0
        send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 2);
        check("t6_zero_done", n_done_a, 7);
        check("t6_zero_data", cap_a, 32'h00);
        check("t6_zero_flags", {cap_err_a, cap_pe_a, cap_fe_a}, 32'b101);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
